// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states,
// default widths and the fetch value returned while the CPU is held.
package imem_pkg;

    localparam int DEFAULT_ADDR_W = 8;
    localparam int DEFAULT_DATA_W = 8;

    localparam logic [7:0] NOP = 8'h00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/imem_ram.sv
// Instruction RAM: one synchronous write port, one asynchronous read port.
// Contents survive reset so a program can be re-run without reloading.
module imem_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Streams a program into the instruction RAM while holding the CPU in reset,
// then releases the CPU and serves combinational fetches at its PC.
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              run,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] read_address,
    output logic [DATA_W-1:0] instruction,
    output logic              cpu_hold,
    output logic [ADDR_W:0]   prog_len,
    output logic [DATA_W-1:0] checksum,
    output logic              overflow
);

    state_t            state_reg;
    logic              in_ready_reg;
    logic              cpu_hold_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W:0]   prog_len_reg;
    logic [DATA_W-1:0] checksum_reg;
    logic              overflow_reg;
    logic [DATA_W-1:0] ram_rdata;
    logic              accept;

    // in_ready_reg is high exactly while in LOAD, so it doubles as the state qualifier
    assign accept = in_valid & in_ready_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            in_ready_reg <= 1'b0;
            cpu_hold_reg <= 1'b1;
            addr_reg     <= '0;
            prog_len_reg <= '0;
            checksum_reg <= '0;
            overflow_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, RUN: begin
                    if (load_start) begin
                        state_reg    <= LOAD;
                        in_ready_reg <= 1'b1;
                        cpu_hold_reg <= 1'b1;
                        addr_reg     <= '0;
                        prog_len_reg <= '0;
                        checksum_reg <= '0;
                        overflow_reg <= 1'b0;
                    end else if (run && state_reg == IDLE) begin
                        state_reg    <= RUN;
                        cpu_hold_reg <= 1'b0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        addr_reg     <= addr_reg + 1'b1;
                        prog_len_reg <= prog_len_reg + (ADDR_W+1)'(1);
                        checksum_reg <= checksum_reg + in_data;
                        // Last word written without in_last: stop rather than wrap over the program
                        if (in_last || addr_reg == '1) begin
                            state_reg    <= RUN;
                            in_ready_reg <= 1'b0;
                            cpu_hold_reg <= 1'b0;
                            overflow_reg <= ~in_last;
                        end
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    in_ready_reg <= 1'b0;
                    cpu_hold_reg <= 1'b1;
                end
            endcase
        end
    end

    imem_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (accept),
        .waddr (addr_reg),
        .wdata (in_data),
        .raddr (read_address),
        .rdata (ram_rdata)
    );

    assign in_ready    = in_ready_reg;
    assign cpu_hold    = cpu_hold_reg;
    assign prog_len    = prog_len_reg;
    assign checksum    = checksum_reg;
    assign overflow    = overflow_reg;
    assign instruction = (state_reg == RUN) ? ram_rdata : DATA_W'(NOP);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: load, gapped load, overflow, reset mid-load,
// simultaneous load_start/run, and reload from RUN.
module tb_imem_loader;

    logic       clk;
    logic       reset;
    logic       load_start;
    logic       run;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;
    logic [7:0] read_address;
    logic [7:0] instruction;
    logic       cpu_hold;
    logic [8:0] prog_len;
    logic [7:0] checksum;
    logic       overflow;

    int total = 0;
    int bad   = 0;

    imem_loader dut (
        .clk          (clk),
        .reset        (reset),
        .load_start   (load_start),
        .run          (run),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .read_address (read_address),
        .instruction  (instruction),
        .cpu_hold     (cpu_hold),
        .prog_len     (prog_len),
        .checksum     (checksum),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // All tasks start and end on a falling edge.
    task automatic pulse_load();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic pulse_run();
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l, input int gap);
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_data  = 8'hEE;
            in_last  = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_ram(input string tag, input logic [7:0] a, input logic [7:0] exp);
        read_address = a;
        #1;
        check(tag, instruction, exp);
    endtask

    task automatic send_prog(input int gap);
        send_byte(8'h11, 1'b0, gap);
        send_byte(8'h22, 1'b0, gap);
        send_byte(8'h33, 1'b0, gap);
        send_byte(8'h44, 1'b1, gap);
    endtask

    initial begin
        reset        = 1'b0;
        load_start   = 1'b0;
        run          = 1'b0;
        in_valid     = 1'b0;
        in_data      = 8'h00;
        in_last      = 1'b0;
        read_address = 8'h00;
        repeat (2) @(negedge clk);

        // reset state
        check("rst_hold", cpu_hold, 1);
        check("rst_ready", in_ready, 0);
        check("rst_len", prog_len, 0);
        check("rst_sum", checksum, 0);
        check("rst_ovf", overflow, 0);
        check("rst_instr", instruction, 8'h00);
        reset = 1'b1;
        @(negedge clk);

        // basic load
        pulse_load();
        check("t1_ready", in_ready, 1);
        check("t1_hold", cpu_hold, 1);
        send_prog(0);
        check("t1_len", prog_len, 4);
        check("t1_sum", checksum, 8'hAA);
        check("t1_hold_fall", cpu_hold, 0);
        check("t1_ready_fall", in_ready, 0);
        check("t1_ovf", overflow, 0);
        check_ram("t1_ram0", 8'd0, 8'h11);
        check_ram("t1_ram1", 8'd1, 8'h22);
        check_ram("t1_ram2", 8'd2, 8'h33);
        check_ram("t1_ram3", 8'd3, 8'h44);

        // gapped load from RUN, junk on in_data/in_last while in_valid low
        read_address = 8'd0;
        pulse_load();
        check("t2_hold", cpu_hold, 1);
        check("t2_instr_nop", instruction, 8'h00);
        check("t2_len_clr", prog_len, 0);
        send_byte(8'h11, 1'b0, 3);
        send_byte(8'h22, 1'b0, 3);
        check("t2_len_mid", prog_len, 2);
        check("t2_ready_mid", in_ready, 1);
        send_byte(8'h33, 1'b0, 3);
        send_byte(8'h44, 1'b1, 3);
        check("t2_len", prog_len, 4);
        check("t2_sum", checksum, 8'hAA);
        check_ram("t2_ram0", 8'd0, 8'h11);
        check_ram("t2_ram1", 8'd1, 8'h22);
        check_ram("t2_ram2", 8'd2, 8'h33);
        check_ram("t2_ram3", 8'd3, 8'h44);

        // overflow: 256 bytes of value i, no in_last
        pulse_load();
        for (int i = 0; i < 256; i++) begin
            send_byte(i[7:0], 1'b0, 0);
        end
        check("t3_ovf", overflow, 1);
        check("t3_len", prog_len, 256);
        check("t3_sum", checksum, 8'h80);
        check("t3_hold", cpu_hold, 0);
        check("t3_ready", in_ready, 0);
        check_ram("t3_ram255", 8'd255, 8'hFF);
        check_ram("t3_ram0", 8'd0, 8'h00);
        check_ram("t3_ram128", 8'd128, 8'h80);

        // reset mid-load; LOAD entry also clears overflow
        pulse_load();
        check("t4_ovf_clr", overflow, 0);
        send_byte(8'h11, 1'b0, 0);
        send_byte(8'h22, 1'b0, 0);
        reset = 1'b0;
        #1;
        check("t4_hold", cpu_hold, 1);
        check("t4_ready", in_ready, 0);
        check("t4_len", prog_len, 0);
        check("t4_sum", checksum, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        pulse_run();
        check("t4_run_hold", cpu_hold, 0);
        check_ram("t4_ram0", 8'd0, 8'h11);
        check_ram("t4_ram1", 8'd1, 8'h22);
        check_ram("t4_ram2", 8'd2, 8'h02);

        // load_start + run together in IDLE; both ignored in LOAD
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        load_start = 1'b1;
        run        = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        run        = 1'b0;
        check("t5_ready", in_ready, 1);
        check("t5_hold", cpu_hold, 1);
        check("t5_instr", instruction, 8'h00);
        send_byte(8'h11, 1'b0, 0);
        send_byte(8'h22, 1'b0, 0);
        load_start = 1'b1;
        run        = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        run        = 1'b0;
        check("t5_ign_ready", in_ready, 1);
        check("t5_ign_len", prog_len, 2);
        send_byte(8'h33, 1'b0, 0);
        send_byte(8'h44, 1'b1, 0);
        check("t5_len", prog_len, 4);
        check("t5_hold_fall", cpu_hold, 0);
        pulse_run();
        check("t5_run_ign", cpu_hold, 0);

        // reload one byte from RUN
        read_address = 8'd0;
        pulse_load();
        check("t6_hold", cpu_hold, 1);
        check("t6_instr", instruction, 8'h00);
        send_byte(8'h5A, 1'b1, 0);
        check("t6_len", prog_len, 1);
        check("t6_sum", checksum, 8'h5A);
        check("t6_ovf", overflow, 0);
        check_ram("t6_ram0", 8'd0, 8'h5A);
        check_ram("t6_ram1", 8'd1, 8'h22);
        check_ram("t6_ram2", 8'd2, 8'h33);
        check_ram("t6_ram3", 8'd3, 8'h44);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Write-side counterpart to the instruction memory read by `Main`. Accepts a program as a byte stream over a valid/ready handshake, stores it in an internal 256×8 instruction RAM and holds the processor in reset while loading. Once the load completes it releases the processor and serves combinational instruction fetches at the processor's `pcc` address.

## Interface
- `ADDR_W`, 8: instruction address width.
- `DATA_W`, 8: instruction width.
- `DEPTH`, 256: RAM words; always equals 2^ADDR_W.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `load_start`  in  1  pulse; begins a program load.
- `run`  in  1  pulse; releases the CPU without loading (uses existing RAM contents).
- `in_valid`  in  1  stream byte valid.
- `in_data`  in  DATA_W  stream byte.
- `in_last`  in  1  marks final byte; qualified by `in_valid`.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `read_address`  in  ADDR_W  fetch address, driven from `pcc`.
- `instruction`  out  DATA_W  fetched instruction.
- `cpu_hold`  out  1  drive to the CPU reset; 1 = CPU held.
- `prog_len`  out  ADDR_W+1  bytes written in the last load, range 0..256.
- `checksum`  out  DATA_W  mod-256 sum of the bytes accepted in the current or last load.
- `overflow`  out  1  sticky; the load filled all 256 words without `in_last`.

## Operation
- States: IDLE, LOAD, RUN.
- IDLE:
  - `load_start` -> LOAD.
  - else `run` -> RUN.
  - Both asserted in the same cycle: LOAD wins.
- LOAD entry clears the write address, `prog_len`, `checksum` and `overflow`.
- LOAD behaviour:
  - `in_ready` = 1.
  - Accept = `in_valid & in_ready`. Each accept writes `in_data` to RAM[addr], increments addr and `prog_len`, and adds the byte to `checksum`, wrapping mod 256.
  - Accept with `in_last` = 1 -> RUN.
  - Accept at addr 255 without `in_last` -> RUN with `overflow` = 1. The address wraps to 0 and never writes past 255.
  - `load_start` and `run` are ignored.
- RUN behaviour:
  - `cpu_hold` = 0.
  - `in_ready` = 0.
  - `load_start` -> LOAD; `run` is ignored.
- `instruction`:
  - RUN: `instruction` = RAM[`read_address`], combinational.
  - IDLE and LOAD: `instruction` = 8'h00.
- `cpu_hold` = 1 in IDLE and LOAD.
- RAM contents are not cleared by reset or by entering LOAD. Unwritten words keep their prior values.

## Timing
- Reset values: state IDLE, `cpu_hold` 1, `in_ready` 0, `prog_len` 0, `checksum` 0, `overflow` 0, `instruction` 8'h00.
- Reset asserted mid-load: immediate return to IDLE, counters cleared, bytes already written stay in RAM.
- `in_ready` is a registered function of state:
  - It rises the cycle after the `load_start` edge.
  - It falls the cycle after the final accept.
- RAM write occurs on the accepting `clk` edge.
- `prog_len` and `checksum` update on the same edge.
- `cpu_hold` falls one cycle after the final accept, or one cycle after `run` in IDLE.
- `cpu_hold` rises one cycle after `load_start` in RUN.
- Fetch latency is 0 cycles (combinational read), matching the existing IMEM behaviour.
- Gaps in `in_valid` are allowed. The loader waits indefinitely, and no state changes without an accept.
- `in_data` and `in_last` are sampled only on an accept.

## Structure
- Shared package `imem_pkg` holds:
  - the state enumeration (IDLE=2'd0, LOAD=2'd1, RUN=2'd2);
  - the `ADDR_W`/`DATA_W` defaults;
  - the `NOP` constant 8'h00.
- Sub-module `imem_ram`: DEPTH×DATA_W, synchronous write port, asynchronous read port, no reset.
- The top level contains the FSM, the address/length/checksum counters and the output muxing.

## Test plan
- Reset, `load_start`, then stream 8'h11, 8'h22, 8'h33, 8'h44 with `in_last` on 8'h44 -> `prog_len`=4, `checksum`=8'hAA, `cpu_hold` falls, `instruction` at addresses 0..3 = 11, 22, 33, 44.
- Same program with `in_valid` deasserted for 3 cycles between every byte -> identical RAM contents, `prog_len`=4, no extra writes.
- 256 bytes of value i without `in_last` -> `overflow`=1, `prog_len`=256, state RUN, RAM[255]=8'hFF, RAM[0]=8'h00.
- `reset` pulsed low after 2 of 4 bytes -> IDLE, `cpu_hold`=1, `prog_len`=0. A following `run` -> RAM[0..1] = 11, 22.
- `load_start` and `run` asserted together in IDLE -> LOAD, `in_ready`=1, `cpu_hold` stays 1.
- In RUN, `load_start` -> `cpu_hold`=1 next cycle, `instruction`=8'h00. Reload of 1 byte 8'h5A with `in_last` -> `prog_len`=1, RAM[0]=5A, RAM[1..3] unchanged.
